// File: rtl/ks_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef logic stage_vld_t;

  function automatic int unsigned ks_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level; bits below SPAN pass through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPAN  = 1
) (
  input  gp_t [WIDTH-1:0] i_gp,
  output gp_t [WIDTH-1:0] o_gp
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    if (i >= int'(SPAN)) begin : g_comb
      assign o_gp[i].g = i_gp[i].g | (i_gp[i-int'(SPAN)].g & i_gp[i].p);
      assign o_gp[i].p = i_gp[i].p & i_gp[i-int'(SPAN)].p;
    end else begin : g_pass
      assign o_gp[i] = i_gp[i];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a
// single global advance enable shared by every stage.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LOG = ks_log2(WIDTH);

  logic                   w_advance;
  logic [WIDTH-1:0]       w_b;
  logic [WIDTH-1:0]       w_pp;
  logic                   w_c0;
  gp_t  [WIDTH-1:0]       w_gp0;
  gp_t  [WIDTH-1:0]       w_gp [0:LOG-1];

  stage_vld_t             r_vld [0:LOG];
  gp_t  [WIDTH-1:0]       r_gp  [0:LOG];
  logic [WIDTH-1:0]       r_p   [0:LOG];
  logic                   r_c0  [0:LOG];

  logic [WIDTH-1:0]       w_carry;
  logic [WIDTH-1:0]       w_sum;
  logic                   w_cout;
  logic                   w_ovf;
  logic                   w_unused_p;

  assign w_advance = out_ready || !out_valid;
  assign in_ready  = w_advance;

  // Carry-in is folded into bit 0's generate so every prefix group includes it.
  always_comb begin
    w_b   = sub ? ~b : b;
    w_c0  = sub | cin;
    w_pp  = a ^ w_b;
    w_gp0 = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_gp0[i].g = a[i] & w_b[i];
      w_gp0[i].p = w_pp[i];
    end
    w_gp0[0].g = (a[0] & w_b[0]) | (w_pp[0] & w_c0);
  end

  for (genvar k = 0; k < int'(LOG); k++) begin : g_lvl
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_lvl (
      .i_gp (r_gp[k]),
      .o_gp (w_gp[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= LOG; k++) begin
        r_vld[k] <= 1'b0;
        r_gp[k]  <= '0;
        r_p[k]   <= '0;
        r_c0[k]  <= 1'b0;
      end
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      r_gp[0]  <= w_gp0;
      r_p[0]   <= w_pp;
      r_c0[0]  <= w_c0;
      for (int unsigned k = 0; k < LOG; k++) begin
        r_vld[k+1] <= r_vld[k];
        r_gp[k+1]  <= w_gp[k];
        r_p[k+1]   <= r_p[k];
        r_c0[k+1]  <= r_c0[k];
      end
    end
  end

  always_comb begin
    w_carry    = '0;
    w_unused_p = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_carry[i] = r_gp[LOG][i].g;
      w_unused_p = w_unused_p ^ r_gp[LOG][i].p;
    end
    w_sum  = r_p[LOG] ^ {w_carry[WIDTH-2:0], r_c0[LOG]};
    w_cout = w_carry[WIDTH-1];
    w_ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH-2];
  end

  if (OUT_REG) begin : g_oreg
    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_vld <= 1'b0;
        r_sum     <= '0;
        r_cout    <= 1'b0;
        r_ovf     <= 1'b0;
      end else if (w_advance) begin
        r_out_vld <= r_vld[LOG];
        r_sum     <= w_sum;
        r_cout    <= w_cout;
        r_ovf     <= w_ovf;
      end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
  end else begin : g_ocomb
    assign out_valid = r_vld[LOG];
    assign sum       = w_sum;
    assign cout      = w_cout;
    assign ovf       = w_ovf;
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe (WIDTH=8, OUT_REG=1) with a result scoreboard.
module tb_ks_adder_pipe;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         cin, sub, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  ks_adder_pipe #(
    .WIDTH   (W),
    .OUT_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  res_t sb[$];
  vec_t tbl[12];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mcin, input logic msub);
    logic [7:0] bb;
    logic [8:0] full;
    res_t       r;
    bb     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + {8'b0, (msub | mcin)};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (ma[7] == bb[7]) && (full[7] != ma[7]);
    return r;
  endfunction

  function automatic res_t exp_of(input vec_t v);
    res_t r;
    r.sum  = v.e_sum;
    r.cout = v.e_cout;
    r.ovf  = v.e_ovf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, consume/push on handshakes.
  task automatic cyc(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                     input logic icin, input logic isub, input logic iordy,
                     input res_t exp, output logic ov, output logic ir, output res_t ores);
    res_t e;
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = iordy;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    ores = '{sum: sum, cout: cout, ovf: ovf};
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out: got out_valid=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        check("sum",  32'(sum),  32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
    if (in_valid && in_ready) sb.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input logic iordy, output logic ov);
    logic ir;
    res_t r;
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, iordy, '0, ov, ir, r);
  endtask

  task automatic drain(input string name);
    logic ov;
    for (int i = 0; i < 30 && sb.size() != 0; i++) idle(1'b1, ov);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ov, ir, any;
    res_t       r, held;
    logic [7:0] ra, rb;
    logic       rc, rs;

    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[2]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[3]  = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7]  = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[8]  = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[9]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[11] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First beat presented right after reset; must appear exactly 5 cycles later.
    cyc(1'b1, tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, 1'b1, exp_of(tbl[0]), ov, ir, r);
    check("first_accept", 32'(ir), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      idle(1'b1, ov);
      check($sformatf("latency_c%0d", k), 32'(ov), 32'(k == 5));
    end

    for (int i = 1; i < 12; i++)
      cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, exp_of(tbl[i]), ov, ir, r);
    drain("table_drain");

    // 20 back-to-back random beats: at full rate the last result leaves 5 cycles after the last beat.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      cyc(1'b1, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), ov, ir, r);
    end
    for (int i = 0; i < 5; i++) idle(1'b1, ov);
    check("thruput_empty", 32'(sb.size()), 32'd0);

    // Fill the pipe, then stall downstream for 3 cycles.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      cyc(1'b1, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), ov, ir, r);
    end
    held = '0;
    for (int s = 0; s < 3; s++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      cyc(1'b1, ra, rb, 1'b0, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), ov, ir, r);
      check("stall_in_ready",  32'(ir), 32'd0);
      check("stall_out_valid", 32'(ov), 32'd1);
      if (s == 0) held = r;
      else check("stall_hold", 32'(r), 32'(held));
    end
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      cyc(1'b1, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), ov, ir, r);
    end
    drain("stall_drain");

    // Asynchronous reset with three beats still in flight.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0, exp_of(tbl[i]), ov, ir, r);
    ov = 1'b0;
    for (int i = 0; i < 10 && !ov; i++) idle(1'b0, ov);
    check("pre_rst_out_valid", 32'(ov), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_sum",       32'(sum),       32'd0);
    check("async_rst_cout",      32'(cout),      32'd0);
    sb.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1, ov);
      any = any | ov;
    end
    check("post_rst_quiet", 32'(any), 32'd0);

    cyc(1'b1, tbl[9].a, tbl[9].b, tbl[9].cin, tbl[9].sub, 1'b1, exp_of(tbl[9]), ov, ir, r);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
